// File: rtl/sobel_gradient_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_gradient_core_if
// Brief    : Window-in / edge-out signal bundle for the Sobel gradient core.
//            The window source drives through the master modport; the core
//            consumes through the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface sobel_gradient_core_if;
  logic [7:0] data_0_i;
  logic [7:0] data_1_i;
  logic [7:0] data_2_i;
  logic [7:0] data_3_i;
  logic [7:0] data_4_i;
  logic [7:0] data_5_i;
  logic [7:0] data_6_i;
  logic [7:0] data_7_i;
  logic [7:0] data_8_i;
  logic       done_i;
  logic [7:0] edge_o;
  logic       done_o;
  logic       frame_done_o;

  modport master (
    output data_0_i, data_1_i, data_2_i,
    output data_3_i, data_4_i, data_5_i,
    output data_6_i, data_7_i, data_8_i,
    output done_i,
    input  edge_o, done_o, frame_done_o
  );

  modport slave (
    input  data_0_i, data_1_i, data_2_i,
    input  data_3_i, data_4_i, data_5_i,
    input  data_6_i, data_7_i, data_8_i,
    input  done_i,
    output edge_o, done_o, frame_done_o
  );
endinterface
`default_nettype wire

// File: rtl/sobel_gradient_core.sv
`default_nettype none
// ============================================================================
// Module   : sobel_gradient_core
// Brief    : Three-stage Sobel edge-magnitude pipeline. Stage 1 forms the
//            four unsigned partial sums, stage 2 the absolute gradients,
//            stage 3 the saturated |Gx|+|Gy| (or a binary edge when
//            SOBEL_THRESH_EN is defined). Counts output pixels and pulses
//            frame_done_o with the last output of each frame.
// Options  : SOBEL_THRESH_EN - binarise against THRESHOLD instead of
//            emitting the saturated magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_gradient_core #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int THRESHOLD  = 100
) (
  input  wire logic           sys_clk_i,
  input  wire logic           sys_rst_i,
  sobel_gradient_core_if.slave bus
);

  // Output pixels per frame: the 3x3 window loses a one-pixel border.
  localparam int c_pix_total = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int c_cnt_w     = $clog2(c_pix_total + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_pix_total - 1);

  // Parameter sanity: the window needs at least a 3x3 image, and the
  // threshold must lie within the reachable 11-bit sum range.
  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_dims
    $error("sobel_gradient_core: image dimensions must be >= 3");
  end
  if (THRESHOLD < 0 || THRESHOLD > 2040) begin : g_bad_threshold
    $error("sobel_gradient_core: THRESHOLD out of range 0..2040");
  end

  // Stage 1 partial sums (each at most 4*255 = 1020)
  logic [9:0] gx_pos_d, gx_pos_q;
  logic [9:0] gx_neg_d, gx_neg_q;
  logic [9:0] gy_pos_d, gy_pos_q;
  logic [9:0] gy_neg_d, gy_neg_q;
  // Stage 2 absolute gradients
  logic [9:0] abs_gx_d, abs_gx_q;
  logic [9:0] abs_gy_d, abs_gy_q;
  // Stage 3 result and control
  logic [10:0]        w_sum;
  logic [7:0]         edge_d, edge_q;
  logic               v1_d, v1_q;
  logic               v2_d, v2_q;
  logic               done_d, done_q;
  logic               frame_done_d, frame_done_q;
  logic [c_cnt_w-1:0] cnt_d, cnt_q;
  logic               w_cnt_at_last;

  // Stage 1: weighted column/row sums; centre tap carries weight 2.
  always_comb begin
    gx_pos_d = {2'b00, bus.data_2_i} + {1'b0, bus.data_5_i, 1'b0} + {2'b00, bus.data_8_i};
    gx_neg_d = {2'b00, bus.data_0_i} + {1'b0, bus.data_3_i, 1'b0} + {2'b00, bus.data_6_i};
    gy_pos_d = {2'b00, bus.data_6_i} + {1'b0, bus.data_7_i, 1'b0} + {2'b00, bus.data_8_i};
    gy_neg_d = {2'b00, bus.data_0_i} + {1'b0, bus.data_1_i, 1'b0} + {2'b00, bus.data_2_i};
  end

  // Stage 2: magnitude as larger minus smaller, so no signed arithmetic.
  always_comb begin
    abs_gx_d = (gx_pos_q >= gx_neg_q) ? (gx_pos_q - gx_neg_q) : (gx_neg_q - gx_pos_q);
    abs_gy_d = (gy_pos_q >= gy_neg_q) ? (gy_pos_q - gy_neg_q) : (gy_neg_q - gy_pos_q);
  end

  // Stage 3: combine gradients; edge only moves when a valid window arrives.
  always_comb begin
    w_sum  = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};
    edge_d = edge_q;
    if (v2_q) begin
`ifdef SOBEL_THRESH_EN
      edge_d = (int'({21'd0, w_sum}) > THRESHOLD) ? 8'hFF : 8'h00;
`else
      edge_d = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
`endif
    end
  end

  // Valid pipeline and frame pixel counter; counter wraps on the last pixel.
  always_comb begin
    v1_d          = bus.done_i;
    v2_d          = v1_q;
    done_d        = v2_q;
    w_cnt_at_last = (cnt_q == c_cnt_last);
    frame_done_d  = v2_q && w_cnt_at_last;
    cnt_d         = cnt_q;
    if (v2_q) begin
      cnt_d = w_cnt_at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Datapath registers; validity is tracked separately so no reset needed.
  always_ff @(posedge sys_clk_i) begin
    gx_pos_q <= gx_pos_d;
    gx_neg_q <= gx_neg_d;
    gy_pos_q <= gy_pos_d;
    gy_neg_q <= gy_neg_d;
    abs_gx_q <= abs_gx_d;
    abs_gy_q <= abs_gy_d;
  end

  // Control and output registers; reset drops any windows still in flight.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      edge_q       <= 8'h00;
      cnt_q        <= '0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      edge_q       <= edge_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.edge_o       = edge_q;
  assign bus.done_o       = done_q;
  assign bus.frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_gradient_core
// Brief    : Directed self-checking bench for sobel_gradient_core on a 5x5
//            image (9 output pixels per frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_gradient_core;

  localparam int c_frame_pix = 9;   // (5-2)*(5-2)

  logic clk;
  logic rst;
  sobel_gradient_core_if u_if();

  sobel_gradient_core #(
    .IMG_WIDTH (5),
    .IMG_HEIGHT(5),
    .THRESHOLD (100)
  ) u_dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-built windows, row-major d0..d8.
  logic [7:0] pat [0:8][0:8] = '{
    '{128,128,128, 128,128,128, 128,128,128}, // flat          -> 0
    '{  0,  0, 10,   0,  0, 10,   0,  0, 10}, // Gx=40         -> 40
    '{  0,255,255,   0,255,255,   0,255,255}, // Gx=1020       -> 255
    '{  0,  0,  0,   0,  0,  0,   0, 30,  0}, // Gy=60         -> 60
    '{  5,  0,  0,   5,  0,  0,   5,  0,  0}, // Gx=-20        -> 20
    '{  0, 50,  0,   0,  0,  0,   0,  0,  0}, // Gy=-100       -> 100
    '{  0,  0,  0,   0,  0,  0,   0,  0, 60}, // Gx=60,Gy=60   -> 120
    '{100,  0,  0,   0,  0,  0,   0,  0,  0}, // Gx=Gy=-100    -> 200
    '{  0,  0,  0,   0,  0, 70,   0, 70,  0}  // Gx=Gy=140     -> 255
  };
`ifdef SOBEL_THRESH_EN
  logic [7:0] exp_edge [0:8] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
`else
  logic [7:0] exp_edge [0:8] = '{8'd0, 8'd40, 8'd255, 8'd60, 8'd20, 8'd100, 8'd120, 8'd200, 8'd255};
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  int out_cnt    = 0;
  int outs_total = 0;
  int last_edge  = 0;
  bit pend_rst   = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one window; when with_rst is set the window coincides with reset.
  task automatic send(input int idx, input bit with_rst);
    u_if.data_0_i = pat[idx][0];
    u_if.data_1_i = pat[idx][1];
    u_if.data_2_i = pat[idx][2];
    u_if.data_3_i = pat[idx][3];
    u_if.data_4_i = pat[idx][4];
    u_if.data_5_i = pat[idx][5];
    u_if.data_6_i = pat[idx][6];
    u_if.data_7_i = pat[idx][7];
    u_if.data_8_i = pat[idx][8];
    u_if.done_i   = 1'b1;
    rst           = with_rst;
    if (!with_rst) exp_q.push_back(exp_edge[idx]);
    @(posedge clk); #1;
    u_if.done_i = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic idle(input int n);
    u_if.done_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Output monitor: scoreboard on done_o, hold and frame checks otherwise.
  always @(negedge clk) begin
    if (pend_rst) begin
      check("rst_edge", u_if.edge_o, 0);
      check("rst_done", u_if.done_o, 0);
      check("rst_frame", u_if.frame_done_o, 0);
      pend_rst  = 1'b0;
      last_edge = 0;
      out_cnt   = 0;
    end else if (u_if.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_done", u_if.done_o, 0);
        last_edge = u_if.edge_o;
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("edge", u_if.edge_o, e);
        out_cnt++;
        outs_total++;
        check("frame_done", u_if.frame_done_o, (out_cnt % c_frame_pix == 0) ? 1 : 0);
        last_edge = e;
      end
    end else begin
      check("done_o_low", u_if.done_o, 0);
      check("frame_wo_done", u_if.frame_done_o, 0);
      check("edge_hold", u_if.edge_o, last_edge);
    end
    if (rst) begin
      exp_q.delete();
      pend_rst = 1'b1;
    end
  end

  initial begin
    int outs_before;
    rst         = 1'b1;
    u_if.done_i = 1'b0;
    u_if.data_0_i = '0; u_if.data_1_i = '0; u_if.data_2_i = '0;
    u_if.data_3_i = '0; u_if.data_4_i = '0; u_if.data_5_i = '0;
    u_if.data_6_i = '0; u_if.data_7_i = '0; u_if.data_8_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_edge", u_if.edge_o, 0);
    check("reset_done", u_if.done_o, 0);
    check("reset_frame", u_if.frame_done_o, 0);
    rst = 1'b0;
    idle(2);

    // Latency: flat window, done_o exactly three cycles after done_i.
    send(0, 1'b0);
    check("lat_c1", u_if.done_o, 0);
    idle(1);
    check("lat_c2", u_if.done_o, 0);
    idle(1);
    check("lat_c3", u_if.done_o, 1);
    check("lat_edge", u_if.edge_o, 0);
    idle(1);
    check("lat_c4", u_if.done_o, 0);
    idle(3);

    // Single windows, then a back-to-back burst.
    send(1, 1'b0);
    idle(4);
    send(2, 1'b0);
    idle(4);
    for (int i = 3; i < 9; i++) send(i, 1'b0);
    idle(5);

    // Fresh frame, 18 windows with random gaps.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    outs_before = outs_total;
    for (int i = 0; i < 18; i++) begin
      send(i % 9, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(6);
    check("out_count", outs_total - outs_before, 18);

    // Reset while three windows are in flight: none may emerge.
    send(6, 1'b0);
    send(7, 1'b0);
    send(8, 1'b1);
    check("flush_edge", u_if.edge_o, 0);
    check("flush_done", u_if.done_o, 0);
    check("flush_frame", u_if.frame_done_o, 0);
    idle(6);

    // Counter restarted: frame_done must land on the 9th output.
    for (int i = 0; i < 9; i++) send((i + 2) % 9, 1'b0);
    idle(6);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute run-time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire

// File: doc/sobel_gradient_core.md
# sobel_gradient_core

Pipelined Sobel edge-magnitude stage directly downstream of the 3x3 window buffer. Consumes one nine-pixel greyscale window per `done_i` strobe and computes horizontal and vertical gradients. Emits a saturated 8-bit magnitude `|Gx| + |Gy|` with a matching valid strobe three cycles later. Counts output pixels and flags the end of each frame for the output writer.

## Interface
- `IMG_WIDTH`, 640: input image width in pixels (>= 3).
- `IMG_HEIGHT`, 480: input image height in pixels (>= 3).
- `THRESHOLD`, 100: binarisation level; used only when `SOBEL_THRESH_EN` is defined.

- `sys_clk_i` input 1: system clock; all logic on its rising edge.
- `sys_rst_i` input 1: reset, synchronous, active-high.
- `data_0_i`..`data_8_i` input 8 each: window pixels, row-major. 0–2 are the top row, 3–5 the middle row, 6–8 the bottom row; left to right within each row.
- `done_i` input 1: window valid, one window per high cycle.
- `edge_o` output 8: gradient magnitude (or binary edge).
- `done_o` output 1: `edge_o` valid, single-cycle per window.
- `frame_done_o` output 1: pulses with the last `done_o` of a frame.

## Operation
- Gradient definitions:
  - Gx = (d2 + 2·d5 + d8) − (d0 + 2·d3 + d6).
  - Gy = (d6 + 2·d7 + d8) − (d0 + 2·d1 + d2).
- Stage 1:
  - Registers four unsigned 10-bit partial sums: Gx positive, Gx negative, Gy positive, Gy negative.
  - Each partial sum has a maximum of 1020.
  - Registers `v1 <= done_i`.
- Stage 2:
  - Registers |Gx| and |Gy| as unsigned 10-bit values, formed as larger minus smaller partial sum.
  - Never uses signed wrap.
  - Registers `v2 <= v1`.
- Stage 3:
  - Computes the 11-bit sum s = |Gx| + |Gy|, with a maximum of 2040.
  - If s > 255, `edge_o` = 255; otherwise `edge_o` = s[7:0].
  - `done_o <= v2`.
- `edge_o` updates only on cycles where `v2` is high, and holds its last value otherwise.
- `done_i` may be asserted back-to-back or with arbitrary gaps. Each window is processed independently; there is no stall or backpressure.
- Pixel counter:
  - Width is `$clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1)`.
  - Increments on each `v2`.
  - When the counter equals N−1, where N = (IMG_WIDTH−2)·(IMG_HEIGHT−2), and `v2` is high: `frame_done_o` is asserted that cycle together with `done_o`, and the counter wraps to 0.
- Reset:
  - Clears `v1`, `v2` and the counter.
  - Clears `edge_o`, `done_o` and `frame_done_o` to 0.
  - Reset has priority over `done_i`.
  - Windows in flight when reset is applied are discarded and never produce `done_o`.

## Timing
- Latency: window presented with `done_i` at cycle n → `edge_o`/`done_o` valid at cycle n+3.
- Throughput: one window per clock.
- Reset values: `edge_o` = 0, `done_o` = 0, `frame_done_o` = 0, counter = 0.
- First valid output can appear 3 cycles after the first post-reset `done_i`.
- `done_i` asserted in the same cycle as `sys_rst_i` is ignored.
- `frame_done_o` is never high without `done_o`.
- After wrap, the next `done_o` is pixel 0 of the following frame.

## Configuration
- `SOBEL_THRESH_EN` defined:
  - Stage 3 outputs `edge_o` = 8'hFF if s > `THRESHOLD`, else 8'h00.
  - The comparison uses the unsaturated 11-bit sum.
- `SOBEL_THRESH_EN` undefined: the saturated magnitude is output as described; `THRESHOLD` is unused.
- Latency, handshake and counter behaviour are identical in both builds.

## Test plan
- Flat window, all pixels 128, one `done_i` → `edge_o` = 0, `done_o` high exactly 3 cycles later.
- d2 = d5 = d8 = 10, others 0 → Gx = 40, Gy = 0, `edge_o` = 40.
- Vertical step (left column 0, middle and right columns 255) → Gx = 1020, `edge_o` = 255 (saturated).
  - With `SOBEL_THRESH_EN` and `THRESHOLD` = 100: same step gives `edge_o` = 8'hFF; the d2/d5/d8 = 10 case gives 8'h00.
- `IMG_WIDTH` = `IMG_HEIGHT` = 5, 18 windows, `done_i` toggling with random gaps → `frame_done_o` on the 9th and 18th `done_o` only.
  - `done_o` count equals `done_i` count.
  - `edge_o` holds during gaps.
- Reset asserted for one cycle while 3 windows are in flight → no `done_o` from those windows.
  - All outputs 0 the cycle after reset.
  - Counter restarts, so the next frame's `frame_done_o` arrives after exactly 9 outputs.
